fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage of the five-stage pipelined MIPS core. It owns the program counter and issues instruction requests to the instruction cache. It presents each fetched instruction and its next-PC (pc+4) to the IF/ID pipeline register as `in_imemload`/`in_npc`, with a valid/stall handshake. It absorbs downstream stalls in a one-entry hold buffer, applies branch/jump redirects resolved in MEM, and freezes permanently on halt.

## Interface
Parameters:
- PC_INIT, 32'h0000_0000, PC value loaded on reset.

Ports:
- CLK  in  1  core clock; all state updates on rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- ihit  in  1  icache returns `imemload` for `imemaddr` this cycle.
- imemload  in  32  instruction word from icache, valid when `ihit`.
- imemREN  out  1  instruction read request.
- imemaddr  out  32  instruction address (word_t), always `pc`.
- stall  in  1  IF/ID cannot accept this cycle (hazard unit or cache miss downstream).
- redirect  in  1  taken branch, jump, jr or jal resolved in MEM; squash fetch.
- redirect_pc  in  32  target PC when `redirect`.
- halt  in  1  halt instruction reached; stop fetching.
- out_valid  out  1  `out_imemload`/`out_npc` hold a real instruction.
- out_imemload  out  32  instruction to IF/ID `in_imemload`.
- out_npc  out  32  pc+4 of that instruction, to IF/ID `in_npc`.
- perf_fetched  out  32  instructions handed to IF/ID (see Configuration).
- perf_stalls  out  32  cycles with `out_valid && stall` (see Configuration).

## Operation
- State machine fetch_state_t: RUN, HELD, HALTED. Reset: state RUN, pc=PC_INIT, buffer empty.
- RUN:
  - imemREN=1, imemaddr=pc.
  - out_valid=ihit; out_imemload=imemload; out_npc=pc+4 (combinational pass-through).
  - ihit && !stall: transfer; pc<=pc+4; stay RUN.
  - ihit && stall: capture imemload and pc+4 into buffer; pc<=pc+4; go HELD.
  - !ihit: pc holds, request held stable.
- HELD:
  - imemREN=0; out_valid=1 from buffer.
  - !stall: transfer; go RUN.
- HALTED: imemREN=0, out_valid=0, pc frozen. Only nRST leaves HALTED.
- Priority each cycle: nRST > halt > redirect > normal.
  - halt: go HALTED next edge, out_valid=0 this cycle.
  - redirect (any non-halted state): pc<={redirect_pc[31:2],2'b00}; buffer dropped; state RUN; out_valid=0 this cycle (squash, even if ihit).
  - redirect while HALTED: ignored.
- Arithmetic: pc+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0.

## Timing
- Reset values: imemREN=1, imemaddr=PC_INIT, out_valid=0 (no ihit), perf counters 0.
- Latency: 0 cycles from ihit to out_valid in RUN.
- Throughput: 1 instruction per cycle when ihit and !stall every cycle.
- After a redirect edge, first request to new target in the next cycle (1-cycle bubble minimum).
- Stall ending in HELD: buffered instruction transfers on the first !stall cycle. New request issues the cycle after, so one bubble.
- Asynchronous nRST mid-request or mid-HELD: buffer discarded, pc=PC_INIT immediately.

## Configuration
- FETCH_PERF_EN defined:
  - perf_fetched increments on each transfer (out_valid && !stall).
  - perf_stalls increments each cycle out_valid && stall.
  - Both saturate at 32'hFFFF_FFFF and freeze in HALTED.
- FETCH_PERF_EN undefined: counter logic absent; ports remain and are tied to 0.

## Structure
- cpu_types_pkg gains `fetch_state_t` enum (RUN, HELD, HALTED) and `localparam word_t PC_STEP = 32'd4`. Reuses existing word_t.
- Sub-module `sat_counter` (32-bit, enable, async active-low reset, saturating) is instantiated twice, only under FETCH_PERF_EN.

## Test plan
- Reset with PC_INIT=0x100, ihit=1 every cycle, stall=0 -> imemaddr 0x100, 0x104, 0x108; out_npc 0x104, 0x108, 0x10C; one instruction per cycle.
- ihit with word 0x2001_0005 while stall=1 for 3 cycles -> HELD, imemREN=0, out_imemload=0x2001_0005 held. Transfers on the first stall=0 cycle. Next imemaddr is pc+4.
- redirect=1, redirect_pc=0x0000_0203, concurrent ihit -> out_valid=0 that cycle; next imemaddr=0x200; buffered data dropped if in HELD.
- halt and redirect asserted together -> HALTED, imemREN=0, pc unchanged. Later redirect ignored; only nRST restarts at PC_INIT.
- PC_INIT=0xFFFF_FFFC, ihit=1 -> out_npc=0x0, next imemaddr=0x0.
- FETCH_PERF_EN, 10 transfers plus 4 stalled-valid cycles -> perf_fetched=10, perf_stalls=4. Without the macro both read 0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared core types; fetch stage state and PC step.
package cpu_types_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {RUN, HELD, HALTED} fetch_state_t;
    localparam word_t PC_STEP = 32'd4;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: 32-bit enabled counter that sticks at all-ones.
module sat_counter
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  nRST,
    input  logic  en,
    output word_t count
);
    always_ff @(posedge CLK or negedge nRST)
        if (!nRST) count <= '0;
        else if (en && count != '1) count <= count + 32'd1;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC owner and icache requester feeding IF/ID with a one-entry hold buffer.
// Performance counters are built only when FETCH_PERF_EN is defined.
module fetch_stage
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000
) (
    input  logic  CLK,
    input  logic  nRST,
    input  logic  ihit,
    input  word_t imemload,
    output logic  imemREN,
    output word_t imemaddr,
    input  logic  stall,
    input  logic  redirect,
    input  word_t redirect_pc,
    input  logic  halt,
    output logic  out_valid,
    output word_t out_imemload,
    output word_t out_npc,
    output word_t perf_fetched,
    output word_t perf_stalls
);
    fetch_state_t state, state_n;
    word_t pc, pc_n, buf_load, buf_load_n, buf_npc, buf_npc_n, pc_inc;

    assign pc_inc = pc + PC_STEP;
    assign imemREN = state == RUN;
    assign imemaddr = pc;
    assign out_imemload = state == HELD ? buf_load : imemload;
    assign out_npc = state == HELD ? buf_npc : pc_inc;
    // halt and redirect both squash whatever is presented this cycle
    assign out_valid = state == HALTED || halt || redirect ? 1'b0 : state == HELD ? 1'b1 : ihit;

    always_ff @(posedge CLK or negedge nRST)
        if (!nRST) begin
            state <= RUN;
            pc <= PC_INIT;
            buf_load <= '0;
            buf_npc <= '0;
        end else begin
            state <= state_n;
            pc <= pc_n;
            buf_load <= buf_load_n;
            buf_npc <= buf_npc_n;
        end

    always_comb begin
        state_n = state;
        pc_n = pc;
        buf_load_n = buf_load;
        buf_npc_n = buf_npc;
        if (state != HALTED) begin
            if (halt) state_n = HALTED;
            else if (redirect) begin
                state_n = RUN;
                pc_n = {redirect_pc[31:2], 2'b00};
            end else case (state)
                RUN: if (ihit) begin
                    pc_n = pc_inc;
                    if (stall) begin
                        state_n = HELD;
                        buf_load_n = imemload;
                        buf_npc_n = pc_inc;
                    end
                end
                HELD: if (!stall) state_n = RUN;
                default: state_n = state;
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    sat_counter u_fetched (.CLK(CLK), .nRST(nRST), .en(out_valid && !stall), .count(perf_fetched));
    sat_counter u_stalls (.CLK(CLK), .nRST(nRST), .en(out_valid && stall), .count(perf_stalls));
`else
    assign perf_fetched = '0;
    assign perf_stalls = '0;
`endif
endmodule
